// File: rtl/cam_fifo_reader.sv
// Camera capture FIFO read side: frame-syncs on vsync and packs href byte pairs into RGB565 pixel writes.
// Optional build macro CAM_LINE_CHECK_EN adds a sticky per-line length / line-count error flag.
module cam_fifo_reader #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [9:0]        fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic              px_we,
  output logic [ADDR_W-1:0] px_addr,
  output logic [15:0]       px_data,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    SYNC_HI = 2'd0,
    SYNC_LO = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  // One spare bit so the address can reach H_PIX*V_LINES and saturate there.
  localparam int              TOTAL_I = H_PIX * V_LINES;
  localparam logic [ADDR_W:0] TOTAL   = (ADDR_W+1)'(TOTAL_I);

  state_t          state_q;
  logic            rd_pend_q;
  logic [ADDR_W:0] addr_q;
  logic            phase_q;
  logic            prev_href_q;
  logic [7:0]      hi_q;

  logic       vs;
  logic       href;
  logic [7:0] byte_in;

  assign vs        = fifo_data[9];
  assign href      = fifo_data[8];
  assign byte_in   = fifo_data[7:0];
  assign dbg_state = state_q;

  // Read handshake: fifo_rd pulses only when enabled, FIFO non-empty and no word in flight;
  // the word it requests sits on fifo_data during the following cycle (rd_pend_q=1) and is consumed then.
  assign fifo_rd = !reset && enable && !fifo_empty && !rd_pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC_HI;
      rd_pend_q   <= 1'b0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      prev_href_q <= 1'b0;
      hi_q        <= '0;
      px_we       <= 1'b0;
      px_addr     <= '0;
      px_data     <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rd_pend_q  <= fifo_rd;
      px_we      <= 1'b0;
      frame_done <= 1'b0;
      if (rd_pend_q) begin
        case (state_q)
          SYNC_HI: begin
            if (vs) state_q <= SYNC_LO;
          end
          SYNC_LO: begin
            // The first vsync-low word opens the frame and is itself an active word.
            if (!vs) begin
              state_q     <= ACTIVE;
              busy        <= 1'b1;
              addr_q      <= '0;
              phase_q     <= href;
              prev_href_q <= href;
              if (href) hi_q <= byte_in;
            end
          end
          ACTIVE: begin
            if (vs) begin
              frame_done  <= 1'b1;
              busy        <= 1'b0;
              state_q     <= SYNC_LO;
              addr_q      <= '0;
              phase_q     <= 1'b0;
              prev_href_q <= 1'b0;
            end else if (href) begin
              prev_href_q <= 1'b1;
              if (!phase_q) begin
                hi_q    <= byte_in;
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                if (addr_q < TOTAL) begin
                  px_we   <= 1'b1;
                  px_addr <= addr_q[ADDR_W-1:0];
                  px_data <= {hi_q, byte_in};
                  addr_q  <= addr_q + (ADDR_W+1)'(1);
                end
              end
            end else begin
              if (prev_href_q) phase_q <= 1'b0;
              prev_href_q <= 1'b0;
            end
          end
          default: state_q <= SYNC_HI;
        endcase
      end else if (!enable && state_q == ACTIVE) begin
        // Aborted frame: resync from scratch, no frame_done.
        state_q     <= SYNC_HI;
        busy        <= 1'b0;
        phase_q     <= 1'b0;
        prev_href_q <= 1'b0;
      end
    end
  end

`ifdef CAM_LINE_CHECK_EN
  localparam int PC_W = $clog2(H_PIX + 2);
  localparam int LC_W = $clog2(V_LINES + 1);

  logic [PC_W-1:0] pix_cnt_q;
  logic [LC_W-1:0] line_cnt_q;
  logic            pix_pair;
  logic            line_end;

  assign pix_pair = rd_pend_q && state_q == ACTIVE && !vs && href && phase_q;
  assign line_end = rd_pend_q && state_q == ACTIVE && !vs && !href && prev_href_q;

  // Counters saturate one past their legal limit so an overrun stays detectable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      line_err   <= 1'b0;
    end else if (state_q != ACTIVE) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else if (line_end) begin
      pix_cnt_q <= '0;
      if (pix_cnt_q != PC_W'(H_PIX)) line_err <= 1'b1;
      if (line_cnt_q == LC_W'(V_LINES)) line_err <= 1'b1;
      else line_cnt_q <= line_cnt_q + LC_W'(1);
    end else if (pix_pair && pix_cnt_q != PC_W'(H_PIX + 1)) begin
      pix_cnt_q <= pix_cnt_q + PC_W'(1);
    end
  end
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_cam_fifo_reader.sv
// Scoreboarded bench for cam_fifo_reader: a FIFO driver feeds words, a frame-level model predicts
// pixel writes and frame_done pulses, and an independent monitor compares DUT outputs against them.
module tb_cam_fifo_reader;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [9:0]    fifo_data;
  logic          fifo_empty;
  logic          fifo_rd;
  logic          px_we;
  logic [AW-1:0] px_addr;
  logic [15:0]   px_data;
  logic          frame_done;
  logic          busy;
  logic          line_err;
  logic [1:0]    dbg_state;

  cam_fifo_reader #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .px_we(px_we), .px_addr(px_addr),
    .px_data(px_data), .frame_done(frame_done), .busy(busy), .line_err(line_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Expected events: bit 19 = frame_done, else {addr, data} of a pixel write.
  logic [19:0] exp_q[$];
  logic [9:0]  fifo_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          pix_seen = 0;
  bit          stall = 1'b0;
  bit          rd_last = 1'b0;
  logic [9:0]  word_out = '0;

  // Reference model state: 0 waiting vsync high, 1 waiting vsync low, 2 in frame.
  int          m_mode = 0;
  int          m_addr = 0;
  logic [7:0]  m_bytes[$];
  bit          m_prev = 1'b0;
  int          m_line_px = 0;
  int          m_lines = 0;
  bit          m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void active_word(input logic [9:0] w);
    logic [AW-1:0] a;
    if (w[8]) begin
      m_bytes.push_back(w[7:0]);
      if (m_bytes.size() == 2) begin
        if (m_addr < H * V) begin
          a = AW'(m_addr);
          exp_q.push_back({1'b0, a, m_bytes[0], m_bytes[1]});
          m_addr++;
        end
        m_line_px++;
        m_bytes.delete();
      end
    end else if (m_prev) begin
      if (m_line_px != H) m_err = 1'b1;
      m_lines++;
      if (m_lines > V) m_err = 1'b1;
      m_line_px = 0;
      m_bytes.delete();
    end
    m_prev = w[8];
  endfunction

  function automatic void model_word(input logic [9:0] w);
    case (m_mode)
      0: if (w[9]) m_mode = 1;
      1: if (!w[9]) begin
        m_mode = 2; m_addr = 0; m_bytes.delete(); m_prev = 1'b0;
        m_line_px = 0; m_lines = 0;
        active_word(w);
      end
      default: if (w[9]) begin
        exp_q.push_back({1'b1, 19'd0});
        m_mode = 1;
      end else active_word(w);
    endcase
  endfunction

  function automatic bit exp_line_err();
`ifdef CAM_LINE_CHECK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  // FIFO driver: data appears the cycle after an accepted read, stalls are random when enabled.
  initial begin
    fifo_data  = '0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (rd_last) fifo_data = word_out;
      fifo_empty = (fifo_q.size() == 0) || (stall && ($urandom_range(0, 2) == 0));
      #1;
      if (fifo_rd) begin
        chk("rd_while_empty", 32'(fifo_empty), 32'd0);
        if (fifo_q.size() > 0) begin
          word_out = fifo_q.pop_front();
          model_word(word_out);
        end
        rd_last = 1'b1;
      end else begin
        rd_last = 1'b0;
      end
    end
  end

  // Monitor: every DUT write or frame pulse must match the head of the expected queue.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (px_we) begin
        pix_seen++;
        if (exp_q.size() == 0) chk("px_unexpected", {12'd0, 1'b0, px_addr, px_data}, 32'hFFFFFFFF);
        else begin
          e = exp_q.pop_front();
          chk("px_write", {12'd0, 1'b0, px_addr, px_data}, {12'd0, e});
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0) chk("frame_done_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("frame_done", {12'd0, e}, {12'd0, 1'b1, 19'd0});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  task automatic push_w(input bit v, input bit h, input int b);
    fifo_q.push_back({v, h, 8'(b)});
  endtask

  task automatic push_line(input int n, input int base);
    for (int i = 0; i < n; i++) push_w(1'b0, 1'b1, base + i);
    push_w(1'b0, 1'b0, 0);
    push_w(1'b0, 1'b0, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((fifo_q.size() != 0 || rd_last) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    #3;
    chk({tag, "_busy"}, 32'(busy), 32'(m_mode == 2));
    chk({tag, "_line_err"}, 32'(line_err), 32'(exp_line_err()));
  endtask

  initial begin
    logic [9:0] stream[$];
    int r;
    int start;
    int t;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_px_we", 32'(px_we), 32'd0);
    chk("rst_px_addr", 32'(px_addr), 32'd0);
    chk("rst_px_data", 32'(px_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_line_err", 32'(line_err), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;

    // Pixel bytes with no preceding vsync pulse are ignored.
    for (int i = 0; i < 6; i++) push_w(1'b0, 1'b1, 8'hA0 + i);
    push_w(1'b0, 1'b0, 0);
    drain();
    check_state("pre_sync");

    // Full nominal frame: 8 pixels 0x0001..0x0E0F then frame_done.
    push_w(1'b1, 1'b0, 0);
    push_w(1'b0, 1'b0, 0);
    push_line(8, 0);
    push_line(8, 8);
    push_w(1'b1, 1'b0, 0);
    drain();
    check_state("frame1");

    // Short line: odd byte dropped, next line continues at addr 3.
    push_w(1'b1, 1'b0, 0);
    push_w(1'b0, 1'b0, 0);
    push_line(7, 16);
    push_line(8, 32);
    push_w(1'b1, 1'b0, 0);
    drain();
    check_state("short_line");

    // Overlong frame saturates at the last address; next frame restarts at 0.
    push_w(1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) push_line(8, 64 + 8 * k);
    push_w(1'b1, 1'b0, 0);
    push_w(1'b0, 1'b0, 0);
    push_line(8, 128);
    push_w(1'b1, 1'b0, 0);
    drain();
    check_state("overflow");

    // Random stream, once without and once with FIFO stalls.
    stream.push_back({1'b1, 1'b0, 8'd0});
    stream.push_back({1'b0, 1'b0, 8'd0});
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) stream.push_back({1'b1, 1'($urandom_range(0, 1)), 8'($urandom)});
      else if (r < 65) stream.push_back({1'b0, 1'b1, 8'($urandom)});
      else stream.push_back({1'b0, 1'b0, 8'($urandom)});
    end
    stream.push_back({1'b1, 1'b0, 8'd0});
    for (int pass = 0; pass < 2; pass++) begin
      stall = (pass == 1);
      foreach (stream[i]) fifo_q.push_back(stream[i]);
      drain();
      check_state(pass == 0 ? "rand_nostall" : "rand_stall");
    end
    stall = 1'b0;

    // Abort mid-frame by dropping enable after 3 pixels.
    push_w(1'b1, 1'b0, 0);
    push_w(1'b0, 1'b0, 0);
    push_line(8, 200);
    push_line(8, 208);
    start = pix_seen;
    t = 0;
    while (pix_seen < start + 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("abort_wait_timeout", 32'd1, 32'd0);
    enable = 1'b0;
    #3;
    chk("abort_busy_before", 32'(busy), 32'd1);
    repeat (8) @(negedge clk);
    fifo_q.delete();
    if (m_mode == 2) m_mode = 0;
    check_state("abort");
    @(negedge clk);
    enable = 1'b1;
    push_w(1'b1, 1'b0, 0);
    push_w(1'b0, 1'b0, 0);
    push_line(8, 100);
    push_w(1'b1, 1'b0, 0);
    drain();
    check_state("after_abort");

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/cam_fifo_reader.md
Name: cam_fifo_reader

Overview:
- Read side of the camera capture FIFO. The capture block writes 10-bit words {vsync, href, data[7:0]}; this block pops them, frame-syncs on vsync, and pairs href-qualified bytes into RGB565 pixels.
- Emits single-cycle pixel writes with a linear frame-buffer address. Sits between the capture FIFO and the frame-buffer RAM, in the system clk domain.

Parameters:
- H_PIX, 160, pixels per line.
- V_LINES, 120, lines per frame.
- ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIX*V_LINES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  permits FIFO reads
- fifo_data  in  10  [9]=vsync, [8]=href, [7:0]=pixel byte
- fifo_empty  in  1  FIFO empty flag
- fifo_rd  out  1  FIFO read strobe; data valid on fifo_data the cycle after
- px_we  out  1  one-cycle pixel write strobe
- px_addr  out  ADDR_W  pixel address, row-major
- px_data  out  16  RGB565 pixel, first byte in [15:8]
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  high while in an active frame
- line_err  out  1  sticky line-length error (see Optional Feature)

Behaviour:
- Reset: all outputs 0; internal addr=0, byte phase=0, prev_href=0, state=SYNC_HI.
- Read engine:
  - fifo_rd=1 for one cycle when enable=1, fifo_empty=0, and no read is outstanding.
  - The word is consumed the next cycle, so throughput is at most one word per 2 clk.
  - fifo_rd is never asserted while fifo_empty=1.
- States, evaluated on each consumed word:
  - SYNC_HI: wait for a word with vsync=1, then go to SYNC_LO.
  - SYNC_LO: wait for a word with vsync=0, then go to ACTIVE; addr=0, phase=0, busy=1. This word is also processed as ACTIVE.
  - ACTIVE, vsync=1: frame_done pulses 1 cycle, busy=0, go to SYNC_LO. addr and phase clear.
  - ACTIVE, href=1, phase=0: latch byte as high byte; phase=1.
  - ACTIVE, href=1, phase=1: px_data={hi,byte}, px_we=1, px_addr=addr; then addr+=1, phase=0. Latency is consumed word to px_we: 1 clk, registered.
  - ACTIVE, href falling (prev_href=1, href=0): end of line. An odd leftover byte (phase=1) is discarded; phase=0.
  - ACTIVE, href=0, no edge: ignored.
- Address bound: when addr has reached H_PIX*V_LINES, further pixels produce no px_we and addr holds (saturates). Cleared at the next frame start.
- enable drop mid-frame: no new reads are issued. An outstanding word is still processed. State goes to SYNC_HI, busy=0, no frame_done.
- Simultaneous vsync=1 and href=1 in ACTIVE: vsync wins; the byte is dropped.
- px_data and px_addr hold their last values when px_we=0.

Optional Feature:
- Macro CAM_LINE_CHECK_EN.
- Defined: a per-line pixel counter is checked at each href falling edge. A count other than H_PIX sets line_err=1; it also sets if more than V_LINES lines occur in one frame. line_err is sticky until reset.
- Undefined: line_err tied to 0, no counters.

Test Plan (H_PIX=4, V_LINES=2, ADDR_W=3):
- Stream vsync 1→0, then 2 lines of 8 href bytes 0x00..0x0F, then vsync=1 → px_we ×8, addr 0..7, px_data 0x0001, 0x0203, …, 0x0E0F; one frame_done.
- Pixel bytes before any vsync 1→0 → no px_we, busy=0.
- Line of 7 href bytes, then href=0 → 3 pixels written. The 7th byte is discarded. The next line's first pixel takes the next addr (3). With the macro defined, line_err=1.
- 20 pixels in one frame → writes only at addr 0..7, no wrap; next frame restarts at addr 0.
- fifo_empty toggled randomly while streaming → fifo_rd never high while empty. Pixel sequence is identical to the no-stall case.
- enable=0 after 3 pixels, then enable=1 with a new vsync sequence → no frame_done for the aborted frame. The new frame starts at addr 0.
